// File: rtl/pq_frontend_pkg.sv
// Shared types for the priority-queue request front-end: the per-cycle
// command issued to the queue and its mapping onto the queue's wrt/read pins.
package pq_frontend_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_PUSH    = 2'd1,
        CMD_POP     = 2'd2,
        CMD_REPLACE = 2'd3
    } cmd_e;

    typedef struct packed {
        logic wrt;
        logic read;
    } pq_ctl_t;

    // Map a command onto the queue's {wrt, read} pins. Without a standalone
    // enqueue, a push is a replace into the empty head (wrt and read together).
    function automatic pq_ctl_t cmd_encode(input cmd_e cmd, input logic enq_ena);
        pq_ctl_t ctl;
        ctl = '{wrt: 1'b0, read: 1'b0};
        case (cmd)
            CMD_PUSH:    ctl = '{wrt: 1'b1, read: !enq_ena};
            CMD_POP:     ctl = '{wrt: 1'b0, read: 1'b1};
            CMD_REPLACE: ctl = '{wrt: 1'b1, read: 1'b1};
            default:     ctl = '{wrt: 1'b0, read: 1'b0};
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/pq_key_fifo.sv
// Synchronous first-word-fall-through FIFO buffering pushed keys until the
// arbiter can hand them to the priority queue.
module pq_key_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage write; the pointer wraps naturally because the depth is a power of two.
    // NOTE: the storage array is deliberately left out of reset -- count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pq_request_frontend.sv
// Front-end for the register-array priority queue: buffers pushed keys,
// arbitrates one queue command per cycle (replace > push > pop > idle),
// returns popped heads on a registered response channel and discards key 0.
module pq_request_frontend
    import pq_frontend_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int QUEUE_SIZE = 4,
    parameter int ENQ_ENA    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_push_valid,
    output logic                  o_push_ready,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop_valid,
    output logic                  o_pop_ready,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_data,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_head,
    output logic                  o_zero_drop
);

    localparam logic ENQ_C = (ENQ_ENA != 0);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  push_accept;
    logic                  fifo_wr;
    logic                  key_issue;
    logic                  slot_free;
    logic                  resp_load;
    cmd_e                  cmd;
    pq_ctl_t               ctl;

    assign o_push_ready = !fifo_full;
    assign push_accept  = i_push_valid && o_push_ready;
    // Key 0 marks an empty queue slot, so it is accepted but never stored.
    assign fifo_wr      = push_accept && (i_push_data != '0);
    assign slot_free    = !o_resp_valid || i_resp_ready;

    pq_key_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_key_fifo (
        .clk    (i_CLK),
        .rst_n  (i_RSTn),
        .wr_en  (fifo_wr),
        .wr_data(i_push_data),
        .rd_en  (key_issue),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

    // Issue arbiter: pick at most one queue command from the sampled queue status.
    // NOTE: cmd gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cmd = CMD_IDLE;
        if (i_pop_valid && !fifo_empty && !i_pq_empty && slot_free) begin
            cmd = CMD_REPLACE;
        end else if (!fifo_empty && !i_pq_full && (ENQ_C || i_pq_empty)) begin
            cmd = CMD_PUSH;
        end else if (i_pop_valid && !i_pq_empty && slot_free) begin
            cmd = CMD_POP;
        end
    end

    assign ctl         = cmd_encode(cmd, ENQ_C);
    assign key_issue   = (cmd == CMD_PUSH) || (cmd == CMD_REPLACE);
    assign resp_load   = (cmd == CMD_POP)  || (cmd == CMD_REPLACE);
    assign o_pq_wrt    = ctl.wrt;
    assign o_pq_read   = ctl.read;
    assign o_pq_data   = key_issue ? fifo_head : '0;
    assign o_pop_ready = resp_load;

    // Response register: capture the queue head on a pop, hold until the consumer takes it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            o_resp_valid <= 1'b0;
            o_resp_data  <= '0;
        end else if (resp_load) begin
            o_resp_valid <= 1'b1;
            o_resp_data  <= i_pq_head;
        end else if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
        end
    end

    // One-cycle pulse flagging that an accepted key 0 was discarded.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            o_zero_drop <= 1'b0;
        end else begin
            o_zero_drop <= push_accept && (i_push_data == '0);
        end
    end

    // The queue can never report full and empty together for a non-zero capacity.
    assert property (@(posedge i_CLK) disable iff (!i_RSTn)
        (QUEUE_SIZE == 0) || !(i_pq_full && i_pq_empty));

endmodule

// File: tb/tb_pq_request_frontend.sv
// Self-checking bench: two front-ends (ENQ_ENA=0 and ENQ_ENA=1) share the
// request stimulus; each talks to its own behavioural max-priority queue and
// is compared every cycle against a behavioural model of the front-end.
module tb_pq_request_frontend;

    localparam int DW   = 16;
    localparam int QCAP = 4;
    localparam int FCAP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop_valid = 1'b0;
    logic          resp_ready = 1'b1;

    // Instance 0 (ENQ_ENA=0) signals
    logic          push_ready0, pop_ready0, resp_valid0, pq_wrt0, pq_read0, zero_drop0;
    logic [DW-1:0] resp_data0, pq_data0;
    logic          pq_full0 = 1'b0, pq_empty0 = 1'b1;
    logic [DW-1:0] pq_head0 = '0;
    // Instance 1 (ENQ_ENA=1) signals
    logic          push_ready1, pop_ready1, resp_valid1, pq_wrt1, pq_read1, zero_drop1;
    logic [DW-1:0] resp_data1, pq_data1;
    logic          pq_full1 = 1'b0, pq_empty1 = 1'b1;
    logic [DW-1:0] pq_head1 = '0;

    int tests  = 0;
    int failed = 0;

    // Behavioural state, index = ENQ_ENA value of the instance
    logic [DW-1:0] fm [2][8];   // push buffer, entry 0 is the oldest key
    int            fcnt [2];
    logic [DW-1:0] qm [2][8];   // queue contents, unordered
    int            qcnt [2];
    logic          rv [2];
    logic [DW-1:0] rd [2];
    logic          zd [2];
    // Per-cycle decisions computed before the edge
    logic          e_rep [2], e_push [2], e_pop [2], e_pr [2];
    logic [DW-1:0] e_head [2];

    always #5 clk = ~clk;

    pq_request_frontend #(.DATA_WIDTH(DW), .QUEUE_SIZE(QCAP), .ENQ_ENA(0), .FIFO_DEPTH(FCAP)) u_e0 (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_push_valid(push_valid), .o_push_ready(push_ready0), .i_push_data(push_data),
        .i_pop_valid(pop_valid), .o_pop_ready(pop_ready0),
        .o_resp_valid(resp_valid0), .i_resp_ready(resp_ready), .o_resp_data(resp_data0),
        .o_pq_wrt(pq_wrt0), .o_pq_read(pq_read0), .o_pq_data(pq_data0),
        .i_pq_full(pq_full0), .i_pq_empty(pq_empty0), .i_pq_head(pq_head0),
        .o_zero_drop(zero_drop0)
    );

    pq_request_frontend #(.DATA_WIDTH(DW), .QUEUE_SIZE(QCAP), .ENQ_ENA(1), .FIFO_DEPTH(FCAP)) u_e1 (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_push_valid(push_valid), .o_push_ready(push_ready1), .i_push_data(push_data),
        .i_pop_valid(pop_valid), .o_pop_ready(pop_ready1),
        .o_resp_valid(resp_valid1), .i_resp_ready(resp_ready), .o_resp_data(resp_data1),
        .o_pq_wrt(pq_wrt1), .o_pq_read(pq_read1), .o_pq_data(pq_data1),
        .i_pq_full(pq_full1), .i_pq_empty(pq_empty1), .i_pq_head(pq_head1),
        .o_zero_drop(zero_drop1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [DW-1:0] q_max(input int i);
        logic [DW-1:0] m;
        m = '0;
        for (int k = 0; k < qcnt[i]; k++) if (qm[i][k] > m) m = qm[i][k];
        return m;
    endfunction

    task automatic q_remove_max(input int i);
        int idx;
        idx = 0;
        for (int k = 1; k < qcnt[i]; k++) if (qm[i][k] > qm[i][idx]) idx = k;
        qm[i][idx] = qm[i][qcnt[i]-1];
        qcnt[i]--;
    endtask

    task automatic q_insert(input int i, input logic [DW-1:0] key);
        qm[i][qcnt[i]] = key;
        qcnt[i]++;
    endtask

    // Present each behavioural queue's status to its front-end.
    task automatic drive_queues();
        pq_full0  = (qcnt[0] == QCAP);
        pq_empty0 = (qcnt[0] == 0);
        pq_head0  = q_max(0);
        pq_full1  = (qcnt[1] == QCAP);
        pq_empty1 = (qcnt[1] == 0);
        pq_head1  = q_max(1);
    endtask

    // Decide this cycle's command for each instance from the priority rules.
    task automatic evaluate();
        for (int i = 0; i < 2; i++) begin
            logic have_key, q_empty, q_full, slot;
            have_key  = (fcnt[i] > 0);
            q_empty   = (qcnt[i] == 0);
            q_full    = (qcnt[i] == QCAP);
            slot      = !rv[i] || resp_ready;
            e_head[i] = q_max(i);
            e_pr[i]   = (fcnt[i] < FCAP);
            e_rep[i]  = pop_valid && have_key && !q_empty && slot;
            e_push[i] = !e_rep[i] && have_key && !q_full && ((i == 1) || q_empty);
            e_pop[i]  = !e_rep[i] && !e_push[i] && pop_valid && !q_empty && slot;
        end
    endtask

    task automatic check_inst(input int i, input logic pr, input logic popr, input logic rvv,
                              input logic [DW-1:0] rdd, input logic wrt, input logic rdp,
                              input logic [DW-1:0] dat, input logic zdrop);
        logic [DW-1:0] key;
        key = (e_rep[i] || e_push[i]) ? fm[i][0] : '0;
        chk($sformatf("e%0d.push_ready", i), 32'(pr),    32'(e_pr[i]));
        chk($sformatf("e%0d.pop_ready", i),  32'(popr),  32'(e_rep[i] || e_pop[i]));
        chk($sformatf("e%0d.resp_valid", i), 32'(rvv),   32'(rv[i]));
        chk($sformatf("e%0d.resp_data", i),  32'(rdd),   32'(rd[i]));
        chk($sformatf("e%0d.pq_wrt", i),     32'(wrt),   32'(e_rep[i] || e_push[i]));
        chk($sformatf("e%0d.pq_read", i),    32'(rdp),
            32'(e_rep[i] || e_pop[i] || (e_push[i] && i == 0)));
        chk($sformatf("e%0d.pq_data", i),    32'(dat),   32'(key));
        chk($sformatf("e%0d.zero_drop", i),  32'(zdrop), 32'(zd[i]));
    endtask

    // Advance the behavioural state across one clock edge.
    task automatic update();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                fcnt[i] = 0; qcnt[i] = 0; rv[i] = 1'b0; rd[i] = '0; zd[i] = 1'b0;
            end else begin
                logic [DW-1:0] key;
                key = fm[i][0];
                if (e_rep[i]) begin
                    q_remove_max(i);
                    q_insert(i, key);
                end else if (e_push[i]) begin
                    q_insert(i, key);
                end else if (e_pop[i]) begin
                    q_remove_max(i);
                end
                if (e_rep[i] || e_push[i]) begin
                    for (int k = 0; k < 7; k++) fm[i][k] = fm[i][k+1];
                    fcnt[i]--;
                end
                zd[i] = 1'b0;
                if (push_valid && e_pr[i]) begin
                    if (push_data == '0) zd[i] = 1'b1;
                    else begin
                        fm[i][fcnt[i]] = push_data;
                        fcnt[i]++;
                    end
                end
                if (e_rep[i] || e_pop[i]) begin
                    rv[i] = 1'b1;
                    rd[i] = e_head[i];
                end else if (resp_ready) begin
                    rv[i] = 1'b0;
                end
            end
        end
    endtask

    // One cycle: compare at the falling edge, then move the models past the rising edge.
    task automatic step();
        @(negedge clk);
        evaluate();
        check_inst(0, push_ready0, pop_ready0, resp_valid0, resp_data0, pq_wrt0, pq_read0, pq_data0, zero_drop0);
        check_inst(1, push_ready1, pop_ready1, resp_valid1, resp_data1, pq_wrt1, pq_read1, pq_data1, zero_drop1);
        @(posedge clk);
        #1;
        update();
        drive_queues();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            fcnt[i] = 0; qcnt[i] = 0; rv[i] = 1'b0; rd[i] = '0; zd[i] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                fm[i][k] = '0;
                qm[i][k] = '0;
            end
        end
        drive_queues();

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst.push_ready1", 32'(push_ready1), 32'd1);
        chk("rst.resp_valid0", 32'(resp_valid0), 32'd0);
        chk("rst.pq_wrt0",     32'(pq_wrt0),     32'd0);
        rst_n = 1'b1;
        step();

        // Push 5, 9, 3 back to back, then pop
        push_valid = 1'b1;
        push_data = 16'd5; step();
        push_data = 16'd9; step();
        push_data = 16'd3; step();
        push_valid = 1'b0;
        step();
        step();
        pop_valid = 1'b1;
        step();
        pop_valid = 1'b0;
        chk("dir.e1.resp_valid", 32'(resp_valid1), 32'd1);
        chk("dir.e1.resp_data",  32'(resp_data1),  32'd9);
        chk("dir.e0.resp_data",  32'(resp_data0),  32'd5);
        step();
        step();

        // Key 0 is accepted and dropped
        push_valid = 1'b1;
        push_data = '0;
        step();
        push_valid = 1'b0;
        chk("zero.e0.pulse", 32'(zero_drop0), 32'd1);
        chk("zero.e1.pulse", 32'(zero_drop1), 32'd1);
        step();
        step();

        // Randomised traffic with occasional zero keys, back-pressure and resets
        for (int n = 0; n < 600; n++) begin
            int phase;
            phase = n / 100;
            push_valid = ($urandom_range(0, 9) < ((phase % 2 == 0) ? 7 : 3));
            push_data  = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 255));
            pop_valid  = ($urandom_range(0, 9) < ((phase % 2 == 0) ? 3 : 6));
            resp_ready = ($urandom_range(0, 3) != 0);
            rst_n      = ($urandom_range(0, 249) != 0);
            step();
        end
        rst_n = 1'b1;
        resp_ready = 1'b1;

        // Fill queue and buffer with no pops, then reset mid-operation
        pop_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        push_valid = 1'b1;
        for (int n = 0; n < 14; n++) begin
            push_data = DW'(n + 20);
            step();
        end
        push_valid = 1'b0;
        chk("fill.e1.push_ready", 32'(push_ready1), 32'd0);
        pop_valid = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pop_valid = 1'b0;
        chk("rst2.e1.push_ready", 32'(push_ready1), 32'd1);
        chk("rst2.e1.resp_valid", 32'(resp_valid1), 32'd0);
        chk("rst2.e0.resp_valid", 32'(resp_valid0), 32'd0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pq_request_frontend.md
Name: pq_request_frontend

Overview:
Front-end sitting directly upstream of the register-array priority queue. It accepts key pushes and pop requests over valid/ready handshakes and buffers pushes in a small FIFO. Each cycle it issues at most one command to the queue: enqueue, dequeue or replace. Popped heads return on a registered response channel. It also enforces the queue's rule that key 0 is reserved as the empty-slot marker.

Parameters:
DATA_WIDTH, 16, key width; must match the queue.
QUEUE_SIZE, 4, queue capacity; informational, used only for assertions.
ENQ_ENA, 0, must equal the queue's ENQ_ENA; when 0 the queue has no standalone enqueue.
FIFO_DEPTH, 4, push-buffer entries; power of two, at least 2.

Ports:
i_CLK  in  1  clock
i_RSTn  in  1  reset, synchronous, active-low
i_push_valid  in  1  push request
o_push_ready  out  1  push accepted (FIFO not full)
i_push_data  in  DATA_WIDTH  key to insert
i_pop_valid  in  1  pop request
o_pop_ready  out  1  pop issued to queue this cycle
o_resp_valid  out  1  popped key available
i_resp_ready  in  1  consumer takes response
o_resp_data  out  DATA_WIDTH  popped key
o_pq_wrt  out  1  to queue i_wrt
o_pq_read  out  1  to queue i_read
o_pq_data  out  DATA_WIDTH  to queue i_data
i_pq_full  in  1  from queue o_full
i_pq_empty  in  1  from queue o_empty
i_pq_head  in  DATA_WIDTH  from queue o_data
o_zero_drop  out  1  one-cycle pulse: zero key discarded

Behaviour:
- Reset: the only clock is i_CLK and the only reset is i_RSTn, which is synchronous and active-low. While i_RSTn is low on an edge: FIFO empty, response register invalid, o_resp_data=0, o_zero_drop=0. All other outputs are combinational from this cleared state: o_pq_wrt, o_pq_read and o_pq_data are 0, o_push_ready=1, o_pop_ready=0. Reset mid-operation discards buffered keys and any pending response without completing them.
- Push accept: a handshake (valid & ready) writes the key into the FIFO at the edge. If i_push_data==0, the key is accepted but not written, and o_zero_drop pulses the following cycle. A key is issuable no earlier than the cycle after acceptance.
- Response slot is free when !o_resp_valid or i_resp_ready.
- Issue decision each cycle, in priority order. Let F = FIFO non-empty, P = i_pop_valid, K = FIFO head.
  1. REPLACE: P & F & !i_pq_empty & slot free. Drive wrt=1, read=1, data=K. Pop FIFO; o_pop_ready=1. Response captures i_pq_head, i.e. pop-then-push order.
  2. PUSH: F & !i_pq_full, and either ENQ_ENA=1 or i_pq_empty. With ENQ_ENA=1 drive wrt=1, read=0. With ENQ_ENA=0 (queue empty) drive wrt=1, read=1, which is a replace into an empty head. data=K; pop FIFO; o_pop_ready=0; no response generated.
  3. POP: P & !i_pq_empty & slot free. Drive wrt=0, read=1; o_pop_ready=1; response captures i_pq_head.
  4. IDLE: wrt=0, read=0, data=0.
- With ENQ_ENA=0 and the queue non-empty, buffered keys wait until they can pair with a pop. A pop on an empty queue is held, with o_pop_ready=0.
- Response register: loaded on the edge of a REPLACE or POP, valid the next cycle, so latency is 1. It holds until a handshake completes. A simultaneous drain and reload gives back-to-back valid with no bubble.
- The queue may be commanded every cycle; i_pq_head/full/empty are used as sampled that cycle.
- Full queue: PUSH is suppressed; REPLACE is still allowed.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits, so full and empty are distinct. A simultaneous accept and issue while full is not permitted because ready is low; while empty, the written key is not issued the same cycle.

Decomposition:
- Package pq_frontend_pkg holds the cmd_e enum (CMD_IDLE, CMD_PUSH, CMD_POP, CMD_REPLACE) and a function encoding cmd_e into {wrt, read} given ENQ_ENA.
- One sub-module, pq_key_fifo: a synchronous FIFO parameterised by DATA_WIDTH and FIFO_DEPTH with wr_en, rd_en, full, empty and first-word-fall-through head.
- The top level holds the issue arbiter, the response register and the zero-drop pulse.

Test Plan:
- ENQ_ENA=1, empty queue. Push 5, 9, 3 on consecutive cycles -> three PUSH issues starting one cycle after each accept, data 5, 9, 3. Then pop -> o_resp_data=9 one cycle after o_pop_ready.
- ENQ_ENA=0, empty queue. Push 7 -> issued as wrt=1, read=1 with data 7. Push 4 afterwards -> held, no issue. Then pop -> REPLACE with data 4, response 7; the queue head becomes 4.
- Push 0 -> o_push_ready=1, o_zero_drop=1 the next cycle, no queue command, FIFO count unchanged.
- Queue full (i_pq_full=1), FIFO holds 6, no pop -> IDLE. Then assert pop with head 12 -> REPLACE with data 6, response 12.
- i_resp_ready=0 and a response pending; pop 8 requested -> o_pop_ready=0 until i_resp_ready=1. The drain and the new pop then occur in the same cycle, with o_resp_valid staying 1.
- Fill the FIFO (4 keys) with the queue full -> o_push_ready=0. Assert reset for one cycle -> FIFO empty, o_resp_valid=0, o_push_ready=1 on the next cycle.
